par_word_packer: RTL

Downstream stage of the 3-bit parity automaton. Samples that automaton's one-bit parity output once per 3-clock group and packs consecutive parity bits into WORD_W-bit words. Completed words are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake for the next consumer. A sticky flag records any word lost to FIFO overflow.

---
 rtl/par_word_packer_if.sv | 11 +
 rtl/par_word_packer.sv | 60 ++++++
 2 files changed

// File: rtl/par_word_packer_if.sv
// par_word_packer_if: packer bus (a_in, word_ready in; word_out/word_valid/level/ovf out)
interface par_word_packer_if #(parameter int WORD_W = 8, parameter int DEPTH = 4);
  logic                       a_in;
  logic [WORD_W-1:0]          word_out;
  logic                       word_valid;
  logic                       word_ready;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic                       ovf;
  modport master (output a_in, word_ready, input word_out, word_valid, level, ovf);
  modport slave  (input a_in, word_ready, output word_out, word_valid, level, ovf);
endinterface

// File: rtl/par_word_packer.sv
// par_word_packer: packs every third a_in bit into WORD_W words, FWFT FIFO out; ports clk, rst, bus(a_in, word_out, word_valid, word_ready, level, ovf)
module par_word_packer #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4,
  parameter int PHASE  = 0
) (
  input logic            clk,
  input logic            rst,
  par_word_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int BW = $clog2(WORD_W);
  logic [1:0]        ph_q, ph_d;
  logic [BW-1:0]     bc_q, bc_d;
  logic [WORD_W-1:0] sr_q, sr_d, word;
  logic [AW:0]       wp_q, wp_d, rp_q, rp_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              samp, push, pop, wr, full, empty;
  always_comb begin
    samp  = ph_q == 2'(PHASE);
    word  = {bus.a_in, sr_q[WORD_W-1:1]};
    push  = samp && bc_q == BW'(WORD_W-1);
    full  = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    empty = wp_q == rp_q;
    pop   = !empty && bus.word_ready;
    // a full FIFO still accepts the word when the head leaves on the same edge
    wr    = push && (!full || pop);
    ph_d  = ph_q == 2'd2 ? 2'd0 : ph_q + 2'd1;
    bc_d  = samp ? (push ? '0 : bc_q + 1'b1) : bc_q;
    sr_d  = samp ? word : sr_q;
    wp_d  = wr ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    ovf_d = ovf_q | (push && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= '0;
      bc_q  <= '0;
      sr_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      bc_q  <= bc_d;
      sr_q  <= sr_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst && wr) mem_q[wp_q[AW-1:0]] <= word;
  assign bus.word_out   = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign bus.word_valid = !empty;
  assign bus.level      = LW'(wp_q - rp_q);
  assign bus.ovf        = ovf_q;
endmodule
